// File: rtl/cdu_pkg.sv
// Shared CDU definitions: loop mode encoding and 800 Hz timing defaults.
// Also used by the read counter and error counter blocks.
package cdu_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_COARSE = 2'd1,
        MODE_FINE   = 2'd2,
        MODE_BAD    = 2'd3
    } cdu_mode_t;

    // CLOCKH cycles per 800 Hz resolver reference cycle (51200 / 800).
    localparam int CDU_DIV          = 64;
    // Phase of the reference sine peak, where the comparators are sampled.
    localparam int CDU_SAMPLE_PHASE = 16;

endpackage

// File: rtl/cdu_mode_ctrl_if.sv
// Channel moding bundle: AGC discretes and comparator flags in, timing
// strobes and loop gating out. The slave side is the mode controller.
interface cdu_mode_ctrl_if;

    logic       AGCZ;
    logic       AGCCA;
    logic       AGCEEC;
    logic       fine1_en;
    logic       coarse_ok;
    logic       fine_ok;
    logic [5:0] phase;
    logic       sample_stb;
    logic       slot_stb;
    logic       rc_clear;
    logic       coarse_en;
    logic       fine_en;
    logic       ec_en;
    logic       ca_mode;
    logic [1:0] mode;

    modport slave (
        input  AGCZ, AGCCA, AGCEEC, fine1_en, coarse_ok, fine_ok,
        output phase, sample_stb, slot_stb, rc_clear, coarse_en, fine_en,
               ec_en, ca_mode, mode
    );

    modport master (
        output AGCZ, AGCCA, AGCEEC, fine1_en, coarse_ok, fine_ok,
        input  phase, sample_stb, slot_stb, rc_clear, coarse_en, fine_en,
               ec_en, ca_mode, mode
    );

endinterface

// File: rtl/cdu_sync2.sv
// Two-flop synchroniser for a slow asynchronous discrete, with a
// parameterised reset value so an active-low input resets deasserted.
module cdu_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Capture then re-register the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/cdu_mode_ctrl.sv
// CDU channel moding and timing sequencer: 800 Hz phase divider, sample
// and slot strobes, and the ZERO -> COARSE -> FINE loop hand-over.
module cdu_mode_ctrl
    import cdu_pkg::*;
#(
    parameter int DIV          = CDU_DIV,
    parameter int SAMPLE_PHASE = CDU_SAMPLE_PHASE,
    parameter int SETTLE       = 4,
    parameter int ZERO_MIN     = 2
) (
    input logic            CLOCKH,
    input logic            rst_n,
    cdu_mode_ctrl_if.slave bus
);

    localparam logic [5:0] PH_LAST    = 6'(DIV - 1);
    localparam logic [5:0] PH_SAMPLE  = 6'(SAMPLE_PHASE);
    localparam logic [3:0] SETTLE_N   = 4'(SETTLE);
    localparam logic [3:0] ZERO_MIN_N = 4'(ZERO_MIN);

    logic [2:0] raw;
    logic [2:0] synced;
    logic       z;
    logic       ca;
    logic       eec;

    logic [5:0] phase_reg;
    logic [5:0] phase_next;
    logic       sample_stb_reg;
    logic       slot_stb_reg;
    logic       ec_en_reg;
    logic       apply;

    cdu_mode_t  mode_reg;
    cdu_mode_t  mode_next;
    logic [3:0] zcnt_reg;
    logic [3:0] zcnt_next;
    logic [3:0] settle_reg;
    logic [3:0] settle_next;
    logic       pend_reg;
    logic       pend_next;

    // Bit order: 0 = zero, 1 = coarse align, 2 = error-counter enable.
    assign raw = {bus.AGCEEC, bus.AGCCA, bus.AGCZ};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        cdu_sync2 #(.RST_VAL(1'b1)) u_sync (
            .clk   (CLOCKH),
            .rst_n (rst_n),
            .d     (raw[gi]),
            .q     (synced[gi])
        );
    end

    // Discretes are active low on the AGC side.
    assign z   = ~synced[0];
    assign ca  = ~synced[1];
    assign eec = ~synced[2];

    assign phase_next = (phase_reg == PH_LAST) ? 6'd0 : phase_reg + 6'd1;
    // A decision latched on the sample strobe lands on the following slot edge.
    assign apply      = (phase_next[1:0] == 2'b11);

    // Phase divider, strobes decoded from the next phase so they align with it.
    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg      <= 6'd0;
            sample_stb_reg <= 1'b0;
            slot_stb_reg   <= 1'b0;
            ec_en_reg      <= 1'b0;
        end else begin
            phase_reg      <= phase_next;
            sample_stb_reg <= (phase_next == PH_SAMPLE);
            slot_stb_reg   <= (phase_next[1:0] == 2'b11);
            ec_en_reg      <= eec;
        end
    end

    // Loop state, ZERO dwell counter, settle counter and pending hand-over.
    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg   <= MODE_ZERO;
            zcnt_reg   <= 4'd0;
            settle_reg <= 4'd0;
            pend_reg   <= 1'b0;
        end else begin
            mode_reg   <= mode_next;
            zcnt_reg   <= zcnt_next;
            settle_reg <= settle_next;
            pend_reg   <= pend_next;
        end
    end

    // Next-state logic; a zero command overrides every other event.
    always_comb begin
        mode_next   = mode_reg;
        zcnt_next   = zcnt_reg;
        settle_next = settle_reg;
        pend_next   = pend_reg;
        if (z) begin
            mode_next   = MODE_ZERO;
            zcnt_next   = 4'd0;
            settle_next = 4'd0;
            pend_next   = 1'b0;
        end else begin
            case (mode_reg)
                MODE_ZERO: begin
                    if (sample_stb_reg) begin
                        zcnt_next = zcnt_reg + 4'd1;
                        if (zcnt_next == ZERO_MIN_N) pend_next = 1'b1;
                    end
                    if (apply && pend_reg) begin
                        mode_next   = MODE_COARSE;
                        pend_next   = 1'b0;
                        zcnt_next   = 4'd0;
                        settle_next = 4'd0;
                    end
                end
                MODE_COARSE: begin
                    if (sample_stb_reg) begin
                        if (bus.coarse_ok && bus.fine1_en && !ca) begin
                            settle_next = settle_reg + 4'd1;
                            if (settle_next == SETTLE_N) begin
                                pend_next   = 1'b1;
                                settle_next = 4'd0;
                            end
                        end else begin
                            settle_next = 4'd0;
                        end
                    end
                    // Hand-over is dropped if fine became unusable meanwhile.
                    if (apply && pend_reg) begin
                        pend_next = 1'b0;
                        if (bus.fine1_en && !ca) mode_next = MODE_FINE;
                    end
                end
                MODE_FINE: begin
                    if (ca || !bus.fine1_en) begin
                        mode_next   = MODE_COARSE;
                        settle_next = 4'd0;
                        pend_next   = 1'b0;
                    end else begin
                        if (sample_stb_reg) begin
                            if (!bus.fine_ok || !bus.coarse_ok) begin
                                settle_next = settle_reg + 4'd1;
                                if (settle_next == SETTLE_N) begin
                                    pend_next   = 1'b1;
                                    settle_next = 4'd0;
                                end
                            end else begin
                                settle_next = 4'd0;
                            end
                        end
                        if (apply && pend_reg) begin
                            mode_next = MODE_COARSE;
                            pend_next = 1'b0;
                        end
                    end
                end
                default: begin
                    mode_next   = MODE_ZERO;
                    zcnt_next   = 4'd0;
                    settle_next = 4'd0;
                    pend_next   = 1'b0;
                end
            endcase
        end
    end

    // Loop gating decoded from the state register, so coarse/fine never overlap.
    assign bus.phase      = phase_reg;
    assign bus.sample_stb = sample_stb_reg;
    assign bus.slot_stb   = slot_stb_reg;
    assign bus.ec_en      = ec_en_reg;
    assign bus.mode       = mode_reg;
    assign bus.rc_clear   = (mode_reg == MODE_ZERO);
    assign bus.coarse_en  = (mode_reg == MODE_COARSE);
    assign bus.fine_en    = (mode_reg == MODE_FINE);
    assign bus.ca_mode    = ca && (mode_reg != MODE_ZERO);

endmodule

// File: tb/tb_cdu_mode_ctrl.sv
// Self-checking bench for cdu_mode_ctrl: scenario tasks plus randomized
// stimulus, checked every clock against a reference model of the rules.
module tb_cdu_mode_ctrl;

    localparam int DIV          = 64;
    localparam int SAMPLE_PHASE = 16;
    localparam int SETTLE       = 4;
    localparam int ZERO_MIN     = 2;
    localparam logic [14:0] RESET_VEC = 15'b000000_0_0_1_0_0_0_0_00;

    logic CLOCKH = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    cdu_mode_ctrl_if bus ();

    cdu_mode_ctrl #(
        .DIV          (DIV),
        .SAMPLE_PHASE (SAMPLE_PHASE),
        .SETTLE       (SETTLE),
        .ZERO_MIN     (ZERO_MIN)
    ) dut (
        .CLOCKH (CLOCKH),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 CLOCKH = ~CLOCKH;

    // Observed outputs: phase, sample, slot, rc_clear, coarse_en, fine_en, ec_en, ca_mode, mode.
    logic [14:0] act_vec;
    assign act_vec = {bus.phase, bus.sample_stb, bus.slot_stb, bus.rc_clear, bus.coarse_en,
                      bus.fine_en, bus.ec_en, bus.ca_mode, bus.mode};

    // ---------------- reference model ----------------
    int m_ph;          // position within the 800 Hz cycle
    int m_mode;        // 0 ZERO, 1 COARSE, 2 FINE
    int m_zero_seen;   // sample instants seen in ZERO with zero released
    int m_run;         // consecutive qualifying sample instants
    bit m_handover;    // decision taken at the sample instant, due at phase 19
    bit m_z, m_ca, m_eec;             // discretes as seen after synchronisation
    bit m_z_last, m_ca_last, m_eec_last; // raw pins captured on the previous edge
    bit m_ec;

    function automatic void model_reset();
        m_ph = 0; m_mode = 0; m_zero_seen = 0; m_run = 0; m_handover = 0;
        m_z = 0; m_ca = 0; m_eec = 0; m_ec = 0;
        m_z_last = 1; m_ca_last = 1; m_eec_last = 1;
    endfunction

    function automatic void model_edge();
        bit at_sample = (m_ph == SAMPLE_PHASE);
        bit at_slot19 = (m_ph == SAMPLE_PHASE + 2);
        if (m_z) begin
            m_mode = 0; m_zero_seen = 0; m_run = 0; m_handover = 0;
        end else if (m_mode == 0) begin
            if (at_sample) begin
                m_zero_seen++;
                if (m_zero_seen == ZERO_MIN) m_handover = 1;
            end
            if (at_slot19 && m_handover) begin
                m_mode = 1; m_handover = 0; m_zero_seen = 0; m_run = 0;
            end
        end else if (m_mode == 1) begin
            if (at_sample) begin
                m_run = (bus.coarse_ok && bus.fine1_en && !m_ca) ? m_run + 1 : 0;
                if (m_run == SETTLE) begin m_handover = 1; m_run = 0; end
            end
            if (at_slot19 && m_handover) begin
                m_handover = 0;
                if (bus.fine1_en && !m_ca) m_mode = 2;
            end
        end else begin
            if (m_ca || !bus.fine1_en) begin
                m_mode = 1; m_run = 0; m_handover = 0;
            end else begin
                if (at_sample) begin
                    m_run = (!bus.fine_ok || !bus.coarse_ok) ? m_run + 1 : 0;
                    if (m_run == SETTLE) begin m_handover = 1; m_run = 0; end
                end
                if (at_slot19 && m_handover) begin m_mode = 1; m_handover = 0; end
            end
        end
        m_ec  = m_eec;
        m_z   = !m_z_last;   m_z_last   = bus.AGCZ;
        m_ca  = !m_ca_last;  m_ca_last  = bus.AGCCA;
        m_eec = !m_eec_last; m_eec_last = bus.AGCEEC;
        m_ph  = (m_ph + 1) % DIV;
    endfunction

    function automatic logic [14:0] exp_now();
        logic [5:0] ph = 6'(m_ph);
        logic [1:0] md = 2'(m_mode);
        return {ph, m_ph == SAMPLE_PHASE, (m_ph % 4) == 3, m_mode == 0, m_mode == 1,
                m_mode == 2, m_ec, m_ca && (m_mode != 0), md};
    endfunction

    task automatic tick();
        @(posedge CLOCKH);
        model_edge();
        @(negedge CLOCKH);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.AGCZ = 1; bus.AGCCA = 1; bus.AGCEEC = 1;
        bus.fine1_en = 1; bus.coarse_ok = 0; bus.fine_ok = 1;
        model_reset();
        #1;
        total++;
        if (act_vec !== RESET_VEC) begin
            bad++; $display("FAIL reset got=%h want=%h", act_vec, RESET_VEC);
        end
        @(negedge CLOCKH); @(negedge CLOCKH);
        rst_n = 1;
        $display("scenario reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_zero_to_coarse();
        for (int t = 0; t < 100; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL zero_to_coarse t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        total++;
        if (bus.mode !== 2'd1 || bus.rc_clear !== 1'b0) begin
            bad++; $display("FAIL zero_to_coarse_end mode=%0d rc_clear=%0b want mode=1 rc_clear=0", bus.mode, bus.rc_clear);
        end
        $display("scenario zero_to_coarse: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_coarse_to_fine();
        bit pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        bus.fine_ok = 1;
        while (m_ph != 0) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL coarse_to_fine t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        for (int c = 0; c < 8; c++) begin
            bus.coarse_ok = pat[c];
            for (int t = 0; t < DIV; t++) begin
                tick(); total++;
                if (act_vec !== exp_now()) begin
                    bad++; $display("FAIL coarse_to_fine t=%0t got=%h want=%h", $time, act_vec, exp_now());
                end
            end
            if (c == 3) begin
                total++;
                if (bus.mode !== 2'd1) begin
                    bad++; $display("FAIL coarse_three_then_gap mode=%0d want=1", bus.mode);
                end
            end
        end
        total++;
        if (bus.mode !== 2'd2 || bus.fine_en !== 1'b1 || bus.coarse_en !== 1'b0) begin
            bad++; $display("FAIL coarse_to_fine_end mode=%0d fine_en=%0b coarse_en=%0b want 2/1/0",
                            bus.mode, bus.fine_en, bus.coarse_en);
        end
        $display("scenario coarse_to_fine: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_fine_exit();
        bit pat[10] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
        bus.coarse_ok = 1;
        for (int c = 0; c < 10; c++) begin
            bus.fine_ok = pat[c];
            for (int t = 0; t < DIV; t++) begin
                tick(); total++;
                if (act_vec !== exp_now()) begin
                    bad++; $display("FAIL fine_exit t=%0t got=%h want=%h", $time, act_vec, exp_now());
                end
            end
            if (c == 5) begin
                total++;
                if (bus.mode !== 2'd2) begin
                    bad++; $display("FAIL fine_alternate mode=%0d want=2", bus.mode);
                end
            end
        end
        total++;
        if (bus.mode !== 2'd1) begin
            bad++; $display("FAIL fine_exit_end mode=%0d want=1", bus.mode);
        end
        bus.fine_ok = 1;
        $display("scenario fine_exit: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_zero_cmd();
        for (int t = 0; t < 6 * DIV; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL zero_cmd t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        total++;
        if (bus.mode !== 2'd2) begin
            bad++; $display("FAIL zero_cmd_prefine mode=%0d want=2", bus.mode);
        end
        for (int t = 0; t < 4 * DIV; t++) begin
            if (t == 40)  bus.AGCZ = 0;
            if (t == 64)  bus.AGCZ = 1;
            if (t == 100) bus.AGCZ = 0;
            if (t == 101) bus.AGCZ = 1;
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL zero_cmd t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
            if (t == 42) begin
                total++;
                if (bus.mode !== 2'd0 || bus.rc_clear !== 1'b1) begin
                    bad++; $display("FAIL zero_cmd_3clk mode=%0d rc_clear=%0b want 0/1", bus.mode, bus.rc_clear);
                end
            end
            if (t == 200) begin
                total++;
                if (bus.mode !== 2'd0) begin
                    bad++; $display("FAIL zero_restart_hold mode=%0d want=0", bus.mode);
                end
            end
            if (t == 215) begin
                total++;
                if (bus.mode !== 2'd1 || bus.rc_clear !== 1'b0) begin
                    bad++; $display("FAIL zero_restart_exit mode=%0d rc_clear=%0b want 1/0", bus.mode, bus.rc_clear);
                end
            end
        end
        $display("scenario zero_cmd: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_ca();
        for (int t = 0; t < 6 * DIV; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL ca t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        total++;
        if (bus.mode !== 2'd2) begin
            bad++; $display("FAIL ca_prefine mode=%0d want=2", bus.mode);
        end
        for (int t = 0; t < 11 * DIV; t++) begin
            if (t == 30) bus.AGCCA = 0;
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL ca t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
            if (t == 32) begin
                total++;
                if (bus.mode !== 2'd1 || bus.ca_mode !== 1'b1) begin
                    bad++; $display("FAIL ca_exit mode=%0d ca_mode=%0b want 1/1", bus.mode, bus.ca_mode);
                end
            end
        end
        total++;
        if (bus.mode !== 2'd1) begin
            bad++; $display("FAIL ca_hold mode=%0d want=1", bus.mode);
        end
        bus.AGCCA = 1;
        $display("scenario ca: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_eec();
        for (int k = 0; k < 2; k++) begin
            bus.AGCEEC = (k == 1);
            for (int t = 1; t <= 6; t++) begin
                tick(); total++;
                if (act_vec !== exp_now()) begin
                    bad++; $display("FAIL eec t=%0t got=%h want=%h", $time, act_vec, exp_now());
                end
                if (t == 2 || t == 3) begin
                    total++;
                    if (bus.ec_en !== ((t == 3) ? (k == 0) : (k == 1))) begin
                        bad++; $display("FAIL eec_latency clk=%0d got=%0b", t, bus.ec_en);
                    end
                end
            end
        end
        $display("scenario eec: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_no_fine1();
        bus.fine1_en = 0; bus.coarse_ok = 1;
        for (int t = 0; t < 10 * DIV; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL no_fine1 t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        total++;
        if (bus.mode !== 2'd1) begin
            bad++; $display("FAIL no_fine1_hold mode=%0d want=1", bus.mode);
        end
        bus.fine1_en = 1;
        for (int t = 0; t < 6 * DIV; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL no_fine1 t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        bus.fine1_en = 0;
        tick(); total++;
        if (bus.mode !== 2'd1 || act_vec !== exp_now()) begin
            bad++; $display("FAIL fine1_drop mode=%0d want=1 got=%h want=%h", bus.mode, act_vec, exp_now());
        end
        bus.fine1_en = 1;
        $display("scenario no_fine1: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40 * DIV; t++) begin
            if (m_ph == 0) begin
                bus.coarse_ok = ($urandom_range(3, 0) != 0);
                bus.fine_ok   = ($urandom_range(3, 0) != 0);
            end
            if ($urandom_range(299, 0) == 0) bus.AGCZ     = ~bus.AGCZ;
            if ($urandom_range(199, 0) == 0) bus.AGCCA    = ~bus.AGCCA;
            if ($urandom_range(49, 0)  == 0) bus.AGCEEC   = ~bus.AGCEEC;
            if ($urandom_range(399, 0) == 0) bus.fine1_en = ~bus.fine1_en;
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL random t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        bus.AGCZ = 1; bus.AGCCA = 1; bus.AGCEEC = 1; bus.fine1_en = 1;
        $display("scenario random: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_async_reset();
        bus.AGCEEC = 0;
        for (int t = 0; t < 10; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL async_reset_pre t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        @(posedge CLOCKH);
        model_edge();
        #3 rst_n = 0;
        #1;
        model_reset();
        total++;
        if (act_vec !== RESET_VEC) begin
            bad++; $display("FAIL async_reset got=%h want=%h", act_vec, RESET_VEC);
        end
        @(negedge CLOCKH); @(negedge CLOCKH);
        rst_n = 1;
        for (int t = 0; t < 100; t++) begin
            tick(); total++;
            if (act_vec !== exp_now()) begin
                bad++; $display("FAIL async_reset_post t=%0t got=%h want=%h", $time, act_vec, exp_now());
            end
        end
        bus.AGCEEC = 1;
        $display("scenario async_reset: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        test_reset();
        test_zero_to_coarse();
        test_coarse_to_fine();
        test_fine_exit();
        test_zero_cmd();
        test_ca();
        test_eec();
        test_no_fine1();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdu_mode_ctrl.md
Name: cdu_mode_ctrl

Overview:
- Moding and timing sequencer for one CDU channel, clocked by the 51.2 kHz AGC clock.
- Divides CLOCKH into the 800 Hz resolver-cycle phase and generates sample and read-counter slot strobes.
- Synchronises the AGC moding discretes (zero, coarse align, error-counter enable) and sequences the ZERO -> COARSE -> FINE loop hand-over that gates the coarse/fine read-counter drive.

Parameters:
- DIV, 64, CLOCKH cycles per 800 Hz reference cycle (51200/800).
- SAMPLE_PHASE, 16, phase value at which sample_stb fires (reference sine peak).
- SETTLE, 4, consecutive qualifying 800 Hz cycles required for a loop transition.
- ZERO_MIN, 2, minimum 800 Hz cycles spent in ZERO after AGCZ deasserts.

Ports:
- CLOCKH  in  1  51.2 kHz clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- AGCZ  in  1  AGC zero command, active low, asynchronous to CLOCKH.
- AGCCA  in  1  AGC coarse-align command, active low, asynchronous.
- AGCEEC  in  1  AGC error-counter enable, active low, asynchronous.
- fine1_en  in  1  static config; 0 = fine system absent, never enter FINE.
- coarse_ok  in  1  coarse comparator within null band; valid on sample_stb.
- fine_ok  in  1  fine comparator within null band; valid on sample_stb.
- phase  out  6  800 Hz phase counter, 0..DIV-1.
- sample_stb  out  1  one-cycle pulse when phase==SAMPLE_PHASE.
- slot_stb  out  1  one-cycle pulse when phase[1:0]==3 (12.8 kHz read-counter step slot).
- rc_clear  out  1  hold read counter at zero.
- coarse_en  out  1  coarse loop drives read counter.
- fine_en  out  1  fine loop drives read counter.
- ec_en  out  1  error counter enabled toward ATCA/AGC.
- ca_mode  out  1  coarse-align mode active.
- mode  out  2  state: 0 ZERO, 1 COARSE, 2 FINE, 3 unused.

Behaviour:
- Reset is asynchronous and active-low; the module has one clock, CLOCKH, and one reset, rst_n.
- Reset values: phase=0, all strobes 0, mode=ZERO, rc_clear=1, coarse_en=0, fine_en=0, ec_en=0, ca_mode=0, all counters 0.
- Discretes: 2-flop synchroniser each, inverted internally to active-high z, ca, eec. The reset value of the synchroniser flops is 1 (deasserted).
- phase increments each clock and wraps DIV-1 -> 0. Strobes are registered and are true in the cycle where phase equals the stated value.
- ec_en = eec_sync, registered, independent of state. ca_mode = ca_sync and (mode != ZERO).
- z asserted from any state: next clock mode=ZERO, rc_clear=1, coarse_en=fine_en=0, settle counter cleared. z takes priority over all other events.
- ZERO: a counter counts sample_stb pulses while z is deasserted. At count ZERO_MIN go to COARSE and drop rc_clear on the same edge.
- COARSE: coarse_en=1. On each sample_stb, if coarse_ok and fine1_en and not ca, settle++, else settle=0. When settle reaches SETTLE go to FINE with settle=0.
- FINE: fine_en=1, coarse_en=0. On each sample_stb, if !fine_ok or !coarse_ok, settle++, else settle=0. Entry to COARSE occurs when settle reaches SETTLE.
- FINE exits immediately to COARSE (next edge) if ca asserts or fine1_en drops.
- coarse_en and fine_en are never both 1; a transition between them takes effect on the same edge.
- Outputs change only on slot-aligned edges except rc_clear assertion. A mode transition computed on sample_stb is applied at the next slot_stb (phase 19).
- If z deasserts and reasserts within ZERO_MIN, the ZERO counter resets.
- mode==3 is unreachable; if reached, recover to ZERO.

Decomposition:
- Shared package cdu_pkg: mode encoding (MODE_ZERO/COARSE/FINE), DIV and SAMPLE_PHASE defaults, reused by read counter and error counter.
- One sub-module: cdu_sync2 (2-flop synchroniser with parameterised reset value), instanced three times.
- Phase divider and FSM stay in this module.

Test Plan:
- Reset then 100 clocks with discretes high and coarse_ok=0 -> phase wraps 63->0, sample_stb at phase 16 and slot_stb at phase 3,7,...; ZERO for 2 sample pulses, then COARSE with rc_clear=0 at the next slot.
- COARSE with coarse_ok=1 and fine1_en=1 for 4 sample pulses -> mode=FINE, fine_en=1, coarse_en=0 at phase 19 of the 4th cycle. With 3 pulses then one 0, the bench must see no transition.
- FINE, fine_ok=0 for 4 cycles -> back to COARSE. Pulsing fine_ok=0 on alternate cycles -> stays FINE.
- FINE, AGCZ low at phase 40 -> rc_clear=1 and mode=ZERO within 3 clocks (sync plus 1). AGCZ high for 1 cycle then low again -> ZERO counter restarts.
- AGCCA low in FINE -> COARSE next edge, ca_mode=1. Keep coarse_ok=1 for 10 cycles -> no FINE entry. AGCEEC low -> ec_en=1 after 3 clocks in any state.
- fine1_en=0 with coarse_ok=1 for 10 cycles -> remains COARSE. Assert rst_n low mid-cycle -> all outputs at reset values asynchronously.
